// File: rtl/chunk_coordinate_scheduler.sv
// Walks every (x, y) point of an N x N chunk in row-major order (x fastest),
// emitting one sign-extended coordinate pair per accepted cycle.
module chunk_coordinate_scheduler #(
  parameter int COORD_WIDTH = 32,
  parameter int SIZE_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COORD_WIDTH-1:0] chunk_x,
  input  logic [COORD_WIDTH-1:0] chunk_y,
  input  logic [SIZE_WIDTH-1:0]  chunk_size,
  input  logic                   out_ready,
  output logic                   ce_out,
  output logic [255:0]           x_out,
  output logic [255:0]           y_out,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] base_x_q, base_x_d;
  logic [COORD_WIDTH-1:0] base_y_q, base_y_d;
  logic [SIZE_WIDTH-1:0]  size_q, size_d;
  logic [SIZE_WIDTH-1:0]  xoff_q, xoff_d;
  logic [SIZE_WIDTH-1:0]  yoff_q, yoff_d;
  logic                   ce_q, ce_d;
  logic [255:0]           x_q, x_d;
  logic [255:0]           y_q, y_d;

  logic [COORD_WIDTH:0]   sum_x, sum_y;
  logic [SIZE_WIDTH-1:0]  last_off;

  // One extra bit of headroom: origin sign-extended, offset zero-extended.
  always_comb begin
    sum_x    = {base_x_q[COORD_WIDTH-1], base_x_q} + (COORD_WIDTH+1)'(xoff_q);
    sum_y    = {base_y_q[COORD_WIDTH-1], base_y_q} + (COORD_WIDTH+1)'(yoff_q);
    last_off = size_q - SIZE_WIDTH'(1);
  end

  always_comb begin
    state_d  = state_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    size_d   = size_q;
    xoff_d   = xoff_q;
    yoff_d   = yoff_q;
    ce_d     = 1'b0;
    x_d      = x_q;
    y_d      = y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_x_d = chunk_x;
          base_y_d = chunk_y;
          size_d   = chunk_size;
          xoff_d   = '0;
          yoff_d   = '0;
          state_d  = (chunk_size != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          ce_d = 1'b1;
          x_d  = {{(256-COORD_WIDTH-1){sum_x[COORD_WIDTH]}}, sum_x};
          y_d  = {{(256-COORD_WIDTH-1){sum_y[COORD_WIDTH]}}, sum_y};
          if (xoff_q == last_off) begin
            xoff_d = '0;
            yoff_d = yoff_q + SIZE_WIDTH'(1);
            if (yoff_q == last_off) begin
              state_d = DONE;
            end
          end else begin
            xoff_d = xoff_q + SIZE_WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_x_q <= '0;
      base_y_q <= '0;
      size_q   <= '0;
      xoff_q   <= '0;
      yoff_q   <= '0;
      ce_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      size_q   <= size_d;
      xoff_q   <= xoff_d;
      yoff_q   <= yoff_d;
      ce_q     <= ce_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign ce_out = ce_q;
  assign x_out  = x_q;
  assign y_out  = y_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_chunk_coordinate_scheduler.sv
// Randomized bench for chunk_coordinate_scheduler against a queue-based model
// of the expected row-major point sequence.
module tb_chunk_coordinate_scheduler;

  logic         clk = 1'b0;
  logic         rst, start, abort, out_ready;
  logic [31:0]  chunk_x, chunk_y;
  logic [15:0]  chunk_size;
  logic         ce_out, busy, done;
  logic [255:0] x_out, y_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chunk_coordinate_scheduler #(
    .COORD_WIDTH(32),
    .SIZE_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .chunk_x   (chunk_x),
    .chunk_y   (chunk_y),
    .chunk_size(chunk_size),
    .out_ready (out_ready),
    .ce_out    (ce_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected coordinate: signed origin plus unsigned offset, sign-extended to 256 bits.
  function automatic logic [255:0] coord(input logic [31:0] base, input int off);
    longint              s;
    logic signed [255:0] w;
    s = longint'($signed(base)) + longint'(off);
    w = s;
    return w;
  endfunction

  // mode: 0 = out_ready high, 1 = toggle 1,0,1,..., 2 = random (with stray starts)
  task automatic run_scan(input logic [31:0] cx, input logic [31:0] cy, input int n,
                          input int mode, input int abort_after);
    int           qx[$];
    int           qy[$];
    int           pulses   = 0;
    int           budget   = 8 * n * n + 20;
    bit           finished = 0;
    bit           stopped  = 0;
    bit           exp_done;
    logic [255:0] ex, ey, last_x, last_y;

    for (int unsigned yy = 0; yy < n; yy++)
      for (int unsigned xx = 0; xx < n; xx++) begin
        qx.push_back(int'(xx));
        qy.push_back(int'(yy));
      end

    last_x = '0;
    last_y = '0;
    start      = 1'b1;
    chunk_x    = cx;
    chunk_y    = cy;
    chunk_size = 16'(n);
    out_ready  = 1'b1;
    tick();
    start = 1'b0;

    for (int unsigned cyc = 0; cyc < budget; cyc++) begin
      if (ce_out) begin
        if (qx.size() == 0) begin
          check("extra_pulse", 1, 0);
        end else begin
          ex = coord(cx, qx.pop_front());
          ey = coord(cy, qy.pop_front());
          check("x_out", x_out, ex);
          check("y_out", y_out, ey);
          last_x = ex;
          last_y = ey;
          pulses++;
        end
      end else if (pulses > 0) begin
        check("hold_x", x_out, last_x);
        check("hold_y", y_out, last_y);
      end
      check("busy_run", busy, 1);
      exp_done = (n == 0) ? (cyc == 0) : (ce_out && qx.size() == 0);
      check("done", done, exp_done);
      if (done || exp_done) begin
        finished = 1;
        break;
      end
      if (abort_after >= 0 && pulses == abort_after) begin
        stopped = 1;
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc[0] == 1'b1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) begin
        start      = ($urandom_range(0, 5) == 0);
        chunk_x    = $urandom;
        chunk_y    = $urandom;
        chunk_size = 16'($urandom);
      end
      tick();
    end
    start = 1'b0;

    if (stopped) begin
      abort     = 1'b1;
      out_ready = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_ce", ce_out, 0);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      repeat (6) begin
        tick();
        check("post_abort_ce", ce_out, 0);
        check("post_abort_done", done, 0);
      end
    end else if (!finished) begin
      check("timeout", 0, 1);
    end else begin
      check("pulse_count", pulses, n * n);
      tick();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_ce", ce_out, 0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    chunk_x    = '0;
    chunk_y    = '0;
    chunk_size = '0;
    tick();
    tick();
    check("rst_ce", ce_out, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    run_scan(32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 0, -1);
    run_scan(32'd5, 32'd7, 3, 1, -1);
    run_scan(32'd9, 32'd9, 0, 0, -1);
    run_scan(32'd100, 32'hFFFF_FF00, 4, 0, 5);
    run_scan(32'd0, 32'd0, 1, 0, -1);
    run_scan(32'h7FFF_FFFF, 32'h7FFF_FFFF, 2, 2, -1);
    run_scan(32'h8000_0000, 32'h8000_0000, 2, 2, -1);

    // abort while idle does nothing; abort together with start launches
    abort = 1'b1;
    tick();
    check("idle_abort_busy", busy, 0);
    start      = 1'b1;
    chunk_size = 16'd2;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_beats_abort", busy, 1);

    // reset in the middle of a scan
    chunk_x    = 32'hFFFF_FFFD;
    chunk_y    = 32'd4;
    chunk_size = 16'd4;
    out_ready  = 1'b1;
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_ce", ce_out, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_ce", ce_out, 0);
    check("mid_rst_x", x_out, 0);
    check("mid_rst_y", y_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    start = 1'b1;
    tick();
    check("rst_start_busy", busy, 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_start_idle", busy, 0);
    check("rst_start_ce", ce_out, 0);

    repeat (10)
      run_scan($urandom, $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
